// File: rtl/seq_overlap_trimmer_pkg.sv
// Shared widths, trim-case and controller-state encodings for the overlap trimmer.
// The payload width is the packing of {ll, ml, offset, last} in the output register.
package seq_overlap_trimmer_pkg;

  localparam int SEQ_LL_BITS     = 16;
  localparam int SEQ_ML_BITS     = 16;
  localparam int SEQ_OFFSET_BITS = 16;
  localparam int SEQ_MIN_MATCH   = 4;
  localparam int SEQ_PAYLOAD_W   = SEQ_LL_BITS + SEQ_ML_BITS + SEQ_OFFSET_BITS + 1;

  typedef enum logic [1:0] {
    TRIM_DROP  = 2'd0,
    TRIM_MATCH = 2'd1,
    TRIM_LIT   = 2'd2
  } trim_case_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } trim_state_e;

endpackage

// File: rtl/seq_overlap_trimmer_if.sv
// Sequence stream in (from job PEs) and out (to entropy front end) with valid/ready.
// master is the upstream/downstream environment, slave is the trimmer.
interface seq_overlap_trimmer_if
  import seq_overlap_trimmer_pkg::*;
#(
  parameter int LL_BITS  = SEQ_LL_BITS,
  parameter int ML_BITS  = SEQ_ML_BITS,
  parameter int OFF_BITS = SEQ_OFFSET_BITS
);

  logic                in_valid;
  logic                in_ready;
  logic [LL_BITS-1:0]  in_ll;
  logic [ML_BITS-1:0]  in_ml;
  logic [OFF_BITS-1:0] in_offset;
  logic                in_eoj;
  logic [ML_BITS-1:0]  in_overlap_len;
  logic                in_delim;

  logic                out_valid;
  logic                out_ready;
  logic [LL_BITS-1:0]  out_ll;
  logic [ML_BITS-1:0]  out_ml;
  logic [OFF_BITS-1:0] out_offset;
  logic                out_last;

  modport master (
    output in_valid, in_ll, in_ml, in_offset, in_eoj, in_overlap_len, in_delim, out_ready,
    input  in_ready, out_valid, out_ll, out_ml, out_offset, out_last
  );

  modport slave (
    input  in_valid, in_ll, in_ml, in_offset, in_eoj, in_overlap_len, in_delim, out_ready,
    output in_ready, out_valid, out_ll, out_ml, out_offset, out_last
  );

endinterface

// File: rtl/seq_overlap_trimmer_trim_calc.sv
// Combinational trim of one sequence against the carried skip count, with
// saturating literal accumulation into pend_lit.
module seq_trim_calc
  import seq_overlap_trimmer_pkg::*;
#(
  parameter int LL_BITS   = SEQ_LL_BITS,
  parameter int ML_BITS   = SEQ_ML_BITS,
  parameter int MIN_MATCH = SEQ_MIN_MATCH
) (
  input  logic [ML_BITS:0]   skip,
  input  logic [LL_BITS-1:0] ll,
  input  logic [ML_BITS-1:0] ml,
  input  logic [LL_BITS-1:0] pend_lit,
  output logic               emit,
  output logic [LL_BITS-1:0] emit_ll,
  output logic [ML_BITS-1:0] emit_ml,
  output logic [ML_BITS:0]   resid,
  output logic [LL_BITS-1:0] pend_next,
  output logic               sat
);

  localparam int W = LL_BITS + ML_BITS + 1;

  logic [W-1:0]       s_w, l_w, lm_w;
  logic [W-1:0]       m_trim_w, l_trim_w, sum_w;
  logic               sum_over;
  logic [LL_BITS-1:0] sum_sat;
  trim_case_e         tcase;

  assign s_w  = W'(skip);
  assign l_w  = W'(ll);
  assign lm_w = W'(ll) + W'(ml);

  always_comb begin
    tcase    = TRIM_LIT;
    m_trim_w = lm_w - s_w;
    l_trim_w = l_w - s_w;
    resid    = '0;
    if (s_w >= lm_w) begin
      tcase = TRIM_DROP;
      resid = (ML_BITS+1)'(s_w - lm_w);
    end else if (s_w >= l_w) begin
      tcase = TRIM_MATCH;
    end
  end

  // Only one of m' / l' is ever added to pend_lit, selected by the case.
  assign sum_w    = W'(pend_lit) + ((tcase == TRIM_MATCH) ? m_trim_w : l_trim_w);
  assign sum_over = sum_w > W'({LL_BITS{1'b1}});
  assign sum_sat  = sum_over ? {LL_BITS{1'b1}} : LL_BITS'(sum_w);

  always_comb begin
    emit      = 1'b0;
    emit_ll   = '0;
    emit_ml   = '0;
    pend_next = pend_lit;
    sat       = 1'b0;
    case (tcase)
      TRIM_MATCH: begin
        if (m_trim_w >= W'(MIN_MATCH)) begin
          emit      = 1'b1;
          emit_ll   = pend_lit;
          emit_ml   = ML_BITS'(m_trim_w);
          pend_next = '0;
        end else begin
          pend_next = sum_sat;
          sat       = sum_over;
        end
      end
      TRIM_LIT: begin
        sat = sum_over;
        if (ml == '0) begin
          pend_next = sum_sat;
        end else begin
          emit      = 1'b1;
          emit_ll   = sum_sat;
          emit_ml   = ml;
          pend_next = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_overlap_trimmer.sv
// Trims job-overlap bytes from the PE sequence stream, folds literal-only
// sequences forward and closes every block with exactly one out_last.
//
// state    | meaning
// ST_IDLE  | output register empty, no pending literals
// ST_ACCUM | output register empty, pend_lit > 0
// ST_HOLD  | output register full; input stalls while out_ready=0
module seq_overlap_trimmer
  import seq_overlap_trimmer_pkg::*;
#(
  parameter int LL_BITS   = SEQ_LL_BITS,
  parameter int ML_BITS   = SEQ_ML_BITS,
  parameter int OFF_BITS  = SEQ_OFFSET_BITS,
  parameter int MIN_MATCH = SEQ_MIN_MATCH
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_overlap_trimmer_if.slave seq,
  output logic                 ll_overflow
);

  localparam int PAY_W = LL_BITS + ML_BITS + OFF_BITS + 1;

  trim_state_e        state_q;
  logic [PAY_W-1:0]   out_q, out_d;
  logic [LL_BITS-1:0] pend_q, pend_d;
  logic [ML_BITS:0]   skip_q, skip_d;
  logic               ovf_q;

  logic               accept, delim, load_out;
  logic               emit, sat;
  logic [LL_BITS-1:0] emit_ll, pend_next;
  logic [ML_BITS-1:0] emit_ml;
  logic [ML_BITS:0]   resid, ovl_w;

  assign seq.in_ready  = (state_q != ST_HOLD) || seq.out_ready;
  assign seq.out_valid = (state_q == ST_HOLD);
  assign {seq.out_ll, seq.out_ml, seq.out_offset, seq.out_last} = out_q;
  assign ll_overflow   = ovf_q;

  assign accept = seq.in_valid && seq.in_ready;
  assign delim  = seq.in_eoj && seq.in_delim;
  assign ovl_w  = {1'b0, seq.in_overlap_len};

  seq_trim_calc #(
    .LL_BITS  (LL_BITS),
    .ML_BITS  (ML_BITS),
    .MIN_MATCH(MIN_MATCH)
  ) u_calc (
    .skip     (skip_q),
    .ll       (seq.in_ll),
    .ml       (seq.in_ml),
    .pend_lit (pend_q),
    .emit     (emit),
    .emit_ll  (emit_ll),
    .emit_ml  (emit_ml),
    .resid    (resid),
    .pend_next(pend_next),
    .sat      (sat)
  );

  // A delimiter without its own match still terminates the block with a
  // literal-only sequence carrying whatever literals are pending.
  always_comb begin
    load_out = emit || delim;
    if (emit) begin
      out_d = {emit_ll, emit_ml, seq.in_offset, delim};
    end else begin
      out_d = {pend_next, {ML_BITS{1'b0}}, {OFF_BITS{1'b0}}, 1'b1};
    end
    pend_d = delim ? '0 : pend_next;
    if (delim) begin
      skip_d = '0;
    end else if (seq.in_eoj) begin
      skip_d = (resid > ovl_w) ? resid : ovl_w;
    end else begin
      skip_d = resid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      pend_q  <= '0;
      skip_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        pend_q <= pend_d;
        skip_q <= skip_d;
        if (sat) begin
          ovf_q <= 1'b1;
        end
        if (load_out) begin
          out_q   <= out_d;
          state_q <= ST_HOLD;
        end else begin
          state_q <= (pend_d != '0) ? ST_ACCUM : ST_IDLE;
        end
      end else if ((state_q == ST_HOLD) && seq.out_ready) begin
        state_q <= (pend_q != '0) ? ST_ACCUM : ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_seq_overlap_trimmer.sv
// Scoreboard bench for seq_overlap_trimmer: a sequence-level model pushes expected
// outputs as inputs are accepted; a monitor pops and compares on each transfer.
module tb_seq_overlap_trimmer;

  localparam int LLB = 16;
  localparam int MLB = 16;
  localparam int OFB = 16;
  localparam int LL_MAX = (1 << LLB) - 1;

  typedef struct {
    int ll;
    int ml;
    int off;
    bit last;
  } exp_t;

  logic clk;
  logic rst;
  logic ll_overflow;
  logic ready_force;
  logic bp_en;
  logic bp_rand;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   m_skip;
  int   m_pend;
  bit   m_ovf;

  seq_overlap_trimmer_if #(.LL_BITS(LLB), .ML_BITS(MLB), .OFF_BITS(OFB)) seq ();

  seq_overlap_trimmer dut (
    .clk        (clk),
    .rst        (rst),
    .seq        (seq),
    .ll_overflow(ll_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign seq.out_ready = bp_en ? bp_rand : ready_force;

  always @(negedge clk) bp_rand = ($urandom_range(0, 3) != 0);

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    int s;
    s = a + b;
    if (s > LL_MAX) begin
      m_ovf = 1'b1;
      s = LL_MAX;
    end
    return s;
  endfunction

  // Reference behaviour of one accepted sequence.
  task automatic model_step(input int ll, input int ml, input int off,
                            input bit eoj, input int ovl, input bit delim);
    int   s, r, mp, lp;
    bit   emit;
    exp_t e;
    s = m_skip;
    r = 0;
    emit = 1'b0;
    e = '{ll: 0, ml: 0, off: 0, last: 1'b0};
    if (s >= ll + ml) begin
      r = s - ll - ml;
    end else if (s >= ll) begin
      mp = ll + ml - s;
      if (mp >= 4) begin
        emit = 1'b1;
        e.ll = m_pend; e.ml = mp; e.off = off;
        m_pend = 0;
      end else begin
        m_pend = sat_add(m_pend, mp);
      end
    end else begin
      lp = ll - s;
      if (ml == 0) begin
        m_pend = sat_add(m_pend, lp);
      end else begin
        emit = 1'b1;
        e.ll = sat_add(m_pend, lp); e.ml = ml; e.off = off;
        m_pend = 0;
      end
    end
    if (eoj && delim) begin
      if (!emit) begin
        emit = 1'b1;
        e.ll = m_pend; e.ml = 0; e.off = 0;
      end
      e.last = 1'b1;
      m_pend = 0;
      m_skip = 0;
    end else if (eoj) begin
      m_skip = (r > ovl) ? r : ovl;
    end else begin
      m_skip = r;
    end
    if (emit) sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    m_skip = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  // Drives one sequence from a negedge, waits (bounded) for in_ready, returns just after the accepting edge.
  task automatic send(input int ll, input int ml, input int off,
                      input bit eoj = 1'b0, input int ovl = 0, input bit delim = 1'b0);
    int n;
    @(negedge clk);
    seq.in_valid       = 1'b1;
    seq.in_ll          = LLB'(ll);
    seq.in_ml          = MLB'(ml);
    seq.in_offset      = OFB'(off);
    seq.in_eoj         = eoj;
    seq.in_overlap_len = MLB'(ovl);
    seq.in_delim       = delim;
    #1;
    n = 0;
    while (!seq.in_ready && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!seq.in_ready) begin
      check_val("in_ready_wait", seq.in_ready, 1);
      seq.in_valid = 1'b0;
    end else begin
      model_step(ll, ml, off, eoj, ovl, delim);
      @(posedge clk);
      #1;
      seq.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_val("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && seq.out_valid && seq.out_ready) begin
      check_val("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val("out_ll", seq.out_ll, e.ll);
        check_val("out_ml", seq.out_ml, e.ml);
        check_val("out_offset", seq.out_offset, e.off);
        check_val("out_last", seq.out_last, e.last);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst = 1'b1;
    bp_en = 1'b0;
    ready_force = 1'b1;
    seq.in_valid = 1'b0;
    seq.in_ll = '0;
    seq.in_ml = '0;
    seq.in_offset = '0;
    seq.in_eoj = 1'b0;
    seq.in_overlap_len = '0;
    seq.in_delim = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_val("rst_out_valid", seq.out_valid, 0);
    check_val("rst_out_ll", seq.out_ll, 0);
    check_val("rst_out_ml", seq.out_ml, 0);
    check_val("rst_out_offset", seq.out_offset, 0);
    check_val("rst_out_last", seq.out_last, 0);
    check_val("rst_ll_overflow", ll_overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through with one-cycle latency.
    send(3, 10, 100);
    check_val("latency_valid", seq.out_valid, 1);
    wait_drain();

    // Overlap trimmed into literals.
    send(0, 0, 0, 1'b1, 2);
    send(5, 8, 50);
    // Overlap trimmed into the match, then a short remainder folded to literals.
    send(0, 0, 0, 1'b1, 7);
    send(5, 8, 60);
    send(0, 0, 0, 1'b1, 7);
    send(5, 5, 70);
    check_val("short_match_no_out", seq.out_valid, 0);
    send(2, 9, 80);
    // Whole sequence dropped, residual beats overlap_len.
    send(0, 0, 0, 1'b1, 20);
    send(4, 6, 0, 1'b1, 3);
    send(12, 4, 90);
    // Literal tail then delimiter.
    send(0, 0, 0, 1'b1, 0);
    send(7, 0, 0, 1'b1, 0, 1'b1);
    send(3, 5, 33);
    // Delimiter on a match sequence, overlap does not cross it.
    send(2, 6, 44, 1'b1, 5, 1'b1);
    send(1, 4, 55);
    // Delimiter with nothing pending gives ll=0 terminator.
    send(0, 0, 0, 1'b1, 9, 1'b1);
    wait_drain();

    // Random stream with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int  ll, ml, ovl;
      bit  eoj, dl;
      ll  = $urandom_range(0, 12);
      ml  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      eoj = ($urandom_range(0, 3) == 0);
      ovl = eoj ? $urandom_range(0, 15) : 0;
      dl  = eoj && ($urandom_range(0, 2) == 0);
      send(ll, ml, $urandom_range(1, 1000), eoj, ovl, dl);
    end
    send(0, 0, 0, 1'b1, 0, 1'b1);
    bp_en = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    check_val("no_ovf_random", ll_overflow, m_ovf);

    // Literal saturation and sticky overflow.
    send(60000, 0, 1);
    send(60000, 0, 2);
    send(1, 5, 3, 1'b1, 0, 1'b1);
    wait_drain();
    check_val("ovf_sticky", ll_overflow, m_ovf);

    // Backpressure hold, then async reset mid-hold.
    ready_force = 1'b0;
    send(3, 4, 11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_val("hold_in_ready", seq.in_ready, 0);
      check_val("hold_valid", seq.out_valid, 1);
      check_val("hold_ll", seq.out_ll, 3);
      check_val("hold_ml", seq.out_ml, 4);
      check_val("hold_off", seq.out_offset, 11);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("async_rst_valid", seq.out_valid, 0);
    check_val("async_rst_ovf", ll_overflow, 0);
    check_val("async_rst_ll", seq.out_ll, 0);
    @(negedge clk);
    rst = 1'b0;
    ready_force = 1'b1;

    // Pending literals and skip discarded by reset.
    send(2, 0, 0, 1'b1, 6);
    check_val("accum_no_out", seq.out_valid, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(3, 5, 77);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
